uart_rx_sequencer: RTL

UART_RX_SEQUENCER -- requirements
Module: uart_rx_sequencer

---
 rtl/uart_rx_sequencer.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_sequencer.sv
// UART receiver with per-frame latched configuration, MSB-first data, optional parity,
// 1/2 stop bits, a 4-entry receive FIFO, RTS flow control and sticky error flags.
module uart_rx_sequencer #(
  parameter int DIV0 = 10416,
  parameter int DIV1 = 5208,
  parameter int DIV2 = 2604,
  parameter int DIV3 = 868
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       RX,
  input  logic [7:0] MODE,
  input  logic       RD_EN,
  input  logic       CLR_ERR,
  output logic [7:0] DATA_OUT,
  output logic       DATA_VALID,
  output logic       RTS,
  output logic       PARITY_ERR,
  output logic       FRAME_ERR,
  output logic       OVERRUN
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;

  localparam logic [15:0] D0 = 16'(DIV0);
  localparam logic [15:0] D1 = 16'(DIV1);
  localparam logic [15:0] D2 = 16'(DIV2);
  localparam logic [15:0] D3 = 16'(DIV3);

  function automatic logic [15:0] div_sel(input logic [1:0] s);
    case (s)
      2'd0:    return D0;
      2'd1:    return D1;
      2'd2:    return D2;
      default: return D3;
    endcase
  endfunction

  logic        rx_meta_q, rxs_q;
  state_t      state_q;
  logic [15:0] cnt_q, div_q;
  logic [2:0]  bit_q;
  logic [7:0]  shreg_q;
  logic        par_q, pe_q, fe_q;
  logic        par_en_q, par_odd_q, one_stop_q;
  logic        push_q, set_pe_q, set_fe_q;
  logic        fe_now;
  logic        unused_mode;

  assign fe_now      = fe_q | ~rxs_q;
  assign unused_mode = ^MODE[4:2];

  always_ff @(posedge Clock) begin
    if (Reset) begin
      rx_meta_q  <= 1'b1;
      rxs_q      <= 1'b1;
      state_q    <= IDLE;
      cnt_q      <= '0;
      div_q      <= '0;
      bit_q      <= '0;
      shreg_q    <= '0;
      par_q      <= 1'b0;
      pe_q       <= 1'b0;
      fe_q       <= 1'b0;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      one_stop_q <= 1'b0;
      push_q     <= 1'b0;
      set_pe_q   <= 1'b0;
      set_fe_q   <= 1'b0;
    end else begin
      rx_meta_q <= RX;
      rxs_q     <= rx_meta_q;
      push_q    <= 1'b0;
      set_pe_q  <= 1'b0;
      set_fe_q  <= 1'b0;
      case (state_q)
        IDLE: if (!rxs_q) begin
          par_en_q   <= MODE[0];
          par_odd_q  <= MODE[1];
          one_stop_q <= MODE[5];
          div_q      <= div_sel(MODE[7:6]);
          // first sample lands mid start bit: floor(DIV/2) clocks from here
          cnt_q      <= (div_sel(MODE[7:6]) >> 1) - 16'd1;
          bit_q      <= '0;
          par_q      <= 1'b0;
          pe_q       <= 1'b0;
          fe_q       <= 1'b0;
          state_q    <= START;
        end
        START: begin
          if (cnt_q != '0) cnt_q <= cnt_q - 16'd1;
          else if (rxs_q) state_q <= IDLE;
          else begin
            cnt_q   <= div_q - 16'd1;
            state_q <= DATA;
          end
        end
        default: begin
          if (cnt_q != '0) cnt_q <= cnt_q - 16'd1;
          else begin
            cnt_q <= div_q - 16'd1;
            case (state_q)
              DATA: begin
                shreg_q <= {shreg_q[6:0], rxs_q};
                par_q   <= par_q ^ rxs_q;
                bit_q   <= bit_q + 3'd1;
                if (bit_q == 3'd7) state_q <= par_en_q ? PARITY : STOP1;
              end
              PARITY: begin
                pe_q    <= par_q ^ rxs_q ^ par_odd_q;
                state_q <= STOP1;
              end
              STOP1: begin
                if (one_stop_q) begin
                  push_q   <= ~(pe_q | fe_now);
                  set_pe_q <= pe_q;
                  set_fe_q <= fe_now;
                  state_q  <= IDLE;
                end else begin
                  fe_q    <= fe_now;
                  state_q <= STOP2;
                end
              end
              default: begin
                push_q   <= ~(pe_q | fe_now);
                set_pe_q <= pe_q;
                set_fe_q <= fe_now;
                state_q  <= IDLE;
              end
            endcase
          end
        end
      endcase
    end
  end

  // Receive FIFO; a write pulse arriving while full only lands if RD_EN frees a slot.
  logic [3:0][7:0] mem_q;
  logic [1:0]      wptr_q, rptr_q;
  logic [2:0]      fcnt_q, fcnt_d;
  logic [7:0]      hold_q;
  logic            rts_q, pe_flag_q, fe_flag_q, ov_flag_q;
  logic            do_pop, do_push, full;

  assign full    = (fcnt_q == 3'd4);
  assign do_pop  = RD_EN && (fcnt_q != 3'd0);
  assign do_push = push_q && (!full || do_pop);
  assign fcnt_d  = fcnt_q + {2'b0, do_push} - {2'b0, do_pop};

  always_ff @(posedge Clock) begin
    if (Reset) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      fcnt_q    <= '0;
      hold_q    <= '0;
      rts_q     <= 1'b1;
      pe_flag_q <= 1'b0;
      fe_flag_q <= 1'b0;
      ov_flag_q <= 1'b0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= shreg_q;
        wptr_q        <= wptr_q + 2'd1;
      end
      if (do_pop) rptr_q <= rptr_q + 2'd1;
      fcnt_q <= fcnt_d;
      if (fcnt_q != 3'd0) hold_q <= mem_q[rptr_q];
      rts_q     <= (fcnt_q <= 3'd2);
      pe_flag_q <= set_pe_q | (pe_flag_q & ~CLR_ERR);
      fe_flag_q <= set_fe_q | (fe_flag_q & ~CLR_ERR);
      ov_flag_q <= (push_q & full & ~RD_EN) | (ov_flag_q & ~CLR_ERR);
    end
  end

  assign DATA_VALID = (fcnt_q != 3'd0);
  assign DATA_OUT   = DATA_VALID ? mem_q[rptr_q] : hold_q;
  assign RTS        = rts_q;
  assign PARITY_ERR = pe_flag_q;
  assign FRAME_ERR  = fe_flag_q;
  assign OVERRUN    = ov_flag_q;

endmodule
